// File: rtl/nvl2_timer.sv
// Cook-time countdown timer: BCD mm:ss entered from the keypad, counted down
// once per second while mag_on is high; timer_done flags a stored time of 00:00.
module nvl2_timer #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mag_on,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       timer_done
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [3:0]    so_q, st_q, mo_q, mt_q;
  logic [3:0]    so_d, st_d, mo_d, mt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          time_zero;

  assign time_zero = (so_q == 4'd0) && (st_q == 4'd0) && (mo_q == 4'd0) && (mt_q == 4'd0);

  always_comb begin
    so_d    = so_q;
    st_d    = st_q;
    mo_d    = mo_q;
    mt_d    = mt_q;
    presc_d = presc_q;
    if (!clearn) begin
      so_d    = '0;
      st_d    = '0;
      mo_d    = '0;
      mt_d    = '0;
      presc_d = '0;
    end else if (mag_on) begin
      if (time_zero) begin
        presc_d = '0;
      end else if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        // BCD borrow chain; seconds tens refills to 5, other digits to 9
        if (so_q != 4'd0) begin
          so_d = so_q - 4'd1;
        end else begin
          so_d = 4'd9;
          if (st_q != 4'd0) begin
            st_d = st_q - 4'd1;
          end else begin
            st_d = 4'd5;
            if (mo_q != 4'd0) begin
              mo_d = mo_q - 4'd1;
            end else begin
              mo_d = 4'd9;
              mt_d = mt_q - 4'd1;
            end
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (key_valid && (key_digit <= 4'd9)) begin
      mt_d    = mo_q;
      mo_d    = st_q;
      st_d    = so_q;
      so_d    = key_digit;
      presc_d = '0;
    end
    done_d = (so_d == 4'd0) && (st_d == 4'd0) && (mo_d == 4'd0) && (mt_d == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      so_q    <= '0;
      st_q    <= '0;
      mo_q    <= '0;
      mt_q    <= '0;
      presc_q <= '0;
      done_q  <= 1'b1;
    end else begin
      so_q    <= so_d;
      st_q    <= st_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign sec_ones   = so_q;
  assign sec_tens   = st_q;
  assign min_ones   = mo_q;
  assign min_tens   = mt_q;
  assign timer_done = done_q;

endmodule

// File: doc/nvl2_timer.md
# nvl2_timer

Cook-time countdown timer for the level-2 microwave controller; the counterpart of the magnetron control block. It holds a BCD mm:ss cook time entered from the keypad. It counts that time down once per second while the magnetron control drives `mag_on` high. It returns `timer_done` to the magnetron control, which uses it to shut the magnetron off.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100: clock cycles per one-second decrement. Legal range is ≥2.

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mag_on` in 1: count enable, driven by the magnetron control output.
- `clearn` in 1: clear button, active-low, level-sensitive.
- `key_valid` in 1: one-cycle strobe; `key_digit` is valid in that cycle.
- `key_digit` in 4: keypad digit, BCD 0–9.
- `sec_ones` out 4: BCD seconds units.
- `sec_tens` out 4: BCD seconds tens.
- `min_ones` out 4: BCD minutes units.
- `min_tens` out 4: BCD minutes tens.
- `timer_done` out 1: registered; 1 whenever the stored time is 00:00.

## Operation
- **State:** four BCD digit registers, a prescaler counter of width clog2(TICKS_PER_SEC), and the `timer_done` register.
- **Derived modes (no explicit state register):**
  - IDLE: time == 0000.
  - SET: time != 0 and `mag_on` = 0.
  - RUN: time != 0 and `mag_on` = 1.
- **Priority per edge:** `rst` > clear (`clearn` = 0) > count (`mag_on` = 1) > key entry.
- **Reset / clear:** all digits 0, prescaler 0, `timer_done` = 1.
- **Key entry:**
  - Accepted only when `key_valid` = 1, `mag_on` = 0, `clearn` = 1 and `key_digit` ≤ 9.
  - Shift left: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`key_digit`. The old `min_tens` is discarded.
  - An accepted key also zeroes the prescaler.
  - Digits 10–15 are ignored. Keys are ignored while `mag_on` = 1.
- **Counting:**
  - While `mag_on` = 1 and time != 0, the prescaler increments.
  - At TICKS_PER_SEC−1 the prescaler wraps to 0 and the time decrements by one second.
  - While `mag_on` = 0 the prescaler holds, so a pause keeps the partial second.
- **Decrement rules (BCD):**
  - `sec_ones` 0→9 with a borrow from `sec_tens`.
  - `sec_tens` 0→5 on a borrow from minutes. Otherwise it decrements normally, so entered values up to 9 are allowed (00:99 → 00:98).
  - `min_ones` 0→9 with a borrow from `min_tens`.
  - No wrap below 00:00.
- **Zero:**
  - When time == 0000 and `mag_on` = 1: no decrement, and the prescaler is held at 0.
  - `timer_done` = (next time == 0000), registered with the digits.

## Timing
- Reset values: `sec_ones` = `sec_tens` = `min_ones` = `min_tens` = 0, `timer_done` = 1.
- Key-entry latency: an accepted key is visible on the digits and `timer_done` in the cycle after the strobe edge.
- First decrement: from prescaler 0 with `mag_on` held high, the decrement occurs on the TICKS_PER_SEC-th rising edge and is visible after it. Each later decrement follows every TICKS_PER_SEC enabled cycles.
- `timer_done`:
  - Rises on the same edge that loads 0000 into the digits, with no extra lag.
  - Falls on the edge that loads the first nonzero key.
- Simultaneous events:
  - `clearn` = 0 together with a tick or key: clear wins.
  - `key_valid` together with `mag_on` = 1: the key is dropped.
- Reset mid-count: the next edge forces the reset values, with no residual prescaler.
- Outputs change only on clock edges; there are no combinational input-to-output paths.

## Test plan
Bench uses TICKS_PER_SEC = 4.
- **Reset:** assert `rst` 2 cycles → digits 0000, `timer_done` = 1; no change with `mag_on` = 1 for 10 cycles.
- **Key entry:** keys 1, 3, 0 with `mag_on` = 0 → display 01:30; `timer_done` drops 1 cycle after key 1. `key_digit` = 0xA is ignored. A key with `mag_on` = 1 is ignored.
- **Countdown:** load 00:02, `mag_on` = 1 → 00:01 after 4 edges, 00:00 after 8 edges with `timer_done` = 1 the same cycle. It stays 0000 for 8 more cycles.
- **Borrow:** 10:00 → 09:59 after 4 edges; 00:99 → 00:98; 01:00 → 00:59.
- **Pause:** load 00:01, `mag_on` high 2 cycles, low 5 cycles, high again → 00:00 reached exactly 2 enabled cycles later.
- **Clear/reset mid-run:** 05:00 running, `clearn` = 0 one cycle (with simultaneous `key_valid`) → 0000, `timer_done` = 1 next cycle. Repeat with `rst` → reset values.
